// File: rtl/sd_spi_card_model_if.sv
// SPI-mode SD link between an initiator (master) and the card model (slave).
interface sd_spi_card_model_if;
    logic sd_sclk;
    logic sd_cs_n;
    logic sd_mosi;
    logic sd_miso;

    modport master (output sd_sclk, output sd_cs_n, output sd_mosi, input sd_miso);
    modport slave  (input sd_sclk, input sd_cs_n, input sd_mosi, output sd_miso);
endinterface

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder with NUM_BLOCKS x 512 B of on-chip RAM.
// Answers CMD0/CMD55/ACMD41/CMD17/CMD24 and exposes the RAM through a back-door read port.
module sd_spi_card_model #(
    parameter int NUM_BLOCKS   = 8,
    parameter int ACMD41_POLLS = 2,
    parameter int READ_GAP     = 2,
    parameter int BUSY_BYTES   = 4,
    localparam int ADDR_W      = $clog2(NUM_BLOCKS * 512)
) (
    input  logic               clk,
    input  logic               rst,
    sd_spi_card_model_if.slave spi,
    input  logic [ADDR_W-1:0]  bd_addr,
    output logic [7:0]         bd_dout,
    output logic               cmd_strobe,
    output logic [5:0]         cmd_index,
    output logic               in_idle,
    output logic               wr_done
);
    localparam int DEPTH = NUM_BLOCKS * 32'sd512;
    localparam int BLK_W = (NUM_BLOCKS > 32'sd1) ? $clog2(NUM_BLOCKS) : 32'sd1;

    typedef enum logic [3:0] {
        HUNT, CMD, NCR, R1, RGAP, RTOK, RDATA, RCRC, WTOK, WDATA, WCRC, WRESP, WBUSY
    } state_t;

    logic [1:0]        sclk_sync_r, cs_sync_r, mosi_sync_r;
    logic              sclk_prev_r;
    logic              cs_n_s, mosi_s, rise_s, fall_s, byte_done_s, cmd_end_s, wr_en_s;
    state_t            state_r, state_next_s, after_byte_s;
    logic [44:0]       shift_r;
    logic [5:0]        cmd_cnt_r, cmd_index_r, idx_s;
    logic [31:0]       arg_s;
    logic [2:0]        bit_cnt_r;
    logic [8:0]        data_cnt_r;
    logic [7:0]        aux_cnt_r, acmd_cnt_r, acmd_inc_s, acmd_next_s;
    logic [7:0]        tx_sh_r, tx_next_s, r1_r, r1_s, rd_data_r, bd_dout_r, rx_byte_s;
    logic              miso_r, cmd_strobe_r, in_idle_r, wr_done_r, app_flag_r, go_rd_r, go_wr_r;
    logic              idle_next_s, illegal_s, addr_err_s, go_rd_s, go_wr_s;
    logic [BLK_W-1:0]  blk_r, blk_next_s;
    logic [ADDR_W-1:0] byte_addr_s;
    logic [7:0]        mem [0:DEPTH-1];

    assign cs_n_s      = cs_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];
    assign rise_s      = ~cs_n_s & sclk_sync_r[1] & ~sclk_prev_r;
    assign fall_s      = ~cs_n_s & ~sclk_sync_r[1] & sclk_prev_r;
    assign byte_done_s = rise_s && (bit_cnt_r == 3'd7);
    assign cmd_end_s   = rise_s && (state_r == CMD) && (cmd_cnt_r == 6'd47);
    assign wr_en_s     = byte_done_s && (state_r == WDATA);
    // shift_r holds command bits 45..1; the live mosi bit completes the frame
    assign idx_s       = shift_r[44:39];
    assign arg_s       = shift_r[38:7];
    assign rx_byte_s   = {shift_r[6:0], mosi_s};
    assign blk_next_s  = BLK_W'(arg_s[31:9] % 23'(NUM_BLOCKS));
    assign byte_addr_s = ADDR_W'({blk_r, 9'd0}) + ADDR_W'(data_cnt_r);
    assign acmd_inc_s  = (acmd_cnt_r < 8'(ACMD41_POLLS)) ? acmd_cnt_r + 8'd1 : acmd_cnt_r;

    assign spi.sd_miso = miso_r;
    assign bd_dout     = bd_dout_r;
    assign cmd_strobe  = cmd_strobe_r;
    assign cmd_index   = cmd_index_r;
    assign in_idle     = in_idle_r;
    assign wr_done     = wr_done_r;

    // Two-flop synchronizers and sclk edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= 2'b00;
            cs_sync_r   <= 2'b11;
            mosi_sync_r <= 2'b11;
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], spi.sd_sclk};
            cs_sync_r   <= {cs_sync_r[0], spi.sd_cs_n};
            mosi_sync_r <= {mosi_sync_r[0], spi.sd_mosi};
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    // Command decode: R1 contents and card-state updates for the frame ending now
    always_comb begin
        idle_next_s = in_idle_r;
        acmd_next_s = acmd_cnt_r;
        illegal_s   = 1'b0;
        addr_err_s  = 1'b0;
        go_rd_s     = 1'b0;
        go_wr_s     = 1'b0;
        case (idx_s)
            6'd0: begin
                idle_next_s = 1'b1;
                acmd_next_s = 8'd0;
            end
            6'd55: idle_next_s = in_idle_r;
            6'd41: begin
                if (app_flag_r) begin
                    acmd_next_s = acmd_inc_s;
                    idle_next_s = (acmd_inc_s >= 8'(ACMD41_POLLS)) ? 1'b0 : in_idle_r;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            6'd17, 6'd24: begin
                illegal_s  = in_idle_r;
                addr_err_s = |arg_s[8:0];
                go_rd_s    = (idx_s == 6'd17) && !in_idle_r && !(|arg_s[8:0]);
                go_wr_s    = (idx_s == 6'd24) && !in_idle_r && !(|arg_s[8:0]);
            end
            default: illegal_s = 1'b1;
        endcase
        r1_s = {2'b00, addr_err_s, 2'b00, illegal_s, 1'b0, idle_next_s};
    end

    // Byte-level successor state, consulted on each completed byte
    always_comb begin
        after_byte_s = state_r;
        case (state_r)
            NCR:   after_byte_s = R1;
            R1: begin
                if (go_rd_r) begin
                    after_byte_s = (READ_GAP == 32'sd0) ? RTOK : RGAP;
                end else if (go_wr_r) begin
                    after_byte_s = WTOK;
                end else begin
                    after_byte_s = HUNT;
                end
            end
            RGAP:  after_byte_s = (aux_cnt_r == 8'(READ_GAP - 32'sd1)) ? RTOK : RGAP;
            RTOK:  after_byte_s = RDATA;
            RDATA: after_byte_s = (data_cnt_r == 9'd511) ? RCRC : RDATA;
            RCRC:  after_byte_s = (aux_cnt_r == 8'd1) ? HUNT : RCRC;
            WTOK:  after_byte_s = (rx_byte_s == 8'hFE) ? WDATA : WTOK;
            WDATA: after_byte_s = (data_cnt_r == 9'd511) ? WCRC : WDATA;
            WCRC:  after_byte_s = (aux_cnt_r == 8'd1) ? WRESP : WCRC;
            WRESP: after_byte_s = (BUSY_BYTES == 32'sd0) ? HUNT : WBUSY;
            WBUSY: after_byte_s = (aux_cnt_r == 8'(BUSY_BYTES - 32'sd1)) ? HUNT : WBUSY;
            default: after_byte_s = HUNT;
        endcase
    end

    // Next state: bit-level hunting for commands, byte-level everywhere else
    always_comb begin
        state_next_s = state_r;
        if (cs_n_s) begin
            state_next_s = HUNT;
        end else if (rise_s) begin
            case (state_r)
                HUNT:    state_next_s = mosi_s ? HUNT : CMD;
                CMD:     state_next_s = (cmd_cnt_r == 6'd47) ? NCR : CMD;
                default: state_next_s = byte_done_s ? after_byte_s : state_r;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Byte presented on miso for the current state
    always_comb begin
        case (state_r)
            R1:      tx_next_s = r1_r;
            RTOK:    tx_next_s = 8'hFE;
            RDATA:   tx_next_s = rd_data_r;
            WRESP:   tx_next_s = 8'h05;
            WBUSY:   tx_next_s = 8'h00;
            default: tx_next_s = 8'hFF;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shifters, counters, card status and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r      <= '1;
            cmd_cnt_r    <= 6'd0;
            bit_cnt_r    <= 3'd0;
            data_cnt_r   <= 9'd0;
            aux_cnt_r    <= 8'd0;
            tx_sh_r      <= 8'hFF;
            miso_r       <= 1'b1;
            cmd_strobe_r <= 1'b0;
            cmd_index_r  <= 6'd0;
            in_idle_r    <= 1'b1;
            acmd_cnt_r   <= 8'd0;
            app_flag_r   <= 1'b0;
            r1_r         <= 8'hFF;
            go_rd_r      <= 1'b0;
            go_wr_r      <= 1'b0;
            blk_r        <= '0;
            wr_done_r    <= 1'b0;
        end else begin
            cmd_strobe_r <= cmd_end_s;
            wr_done_r    <= wr_en_s && (data_cnt_r == 9'd511);
            if (cs_n_s) begin
                cmd_cnt_r  <= 6'd0;
                bit_cnt_r  <= 3'd0;
                data_cnt_r <= 9'd0;
                aux_cnt_r  <= 8'd0;
                tx_sh_r    <= 8'hFF;
                miso_r     <= 1'b1;
            end else begin
                if (rise_s) begin
                    shift_r   <= {shift_r[43:0], mosi_s};
                    cmd_cnt_r <= (state_next_s == CMD) ? cmd_cnt_r + 6'd1 : 6'd0;
                    bit_cnt_r <= (state_r == HUNT || state_r == CMD) ? 3'd0 : bit_cnt_r + 3'd1;
                end
                if (byte_done_s) begin
                    aux_cnt_r  <= (after_byte_s != state_r) ? 8'd0 : aux_cnt_r + 8'd1;
                    data_cnt_r <= (state_r == RDATA || state_r == WDATA) ? data_cnt_r + 9'd1 : 9'd0;
                end
                // A fresh byte is loaded on the fall that follows each byte boundary
                if (fall_s) begin
                    if (bit_cnt_r == 3'd0) begin
                        miso_r  <= tx_next_s[7];
                        tx_sh_r <= {tx_next_s[6:0], 1'b1};
                    end else begin
                        miso_r  <= tx_sh_r[7];
                        tx_sh_r <= {tx_sh_r[6:0], 1'b1};
                    end
                end
                if (cmd_end_s) begin
                    cmd_index_r <= idx_s;
                    in_idle_r   <= idle_next_s;
                    acmd_cnt_r  <= acmd_next_s;
                    app_flag_r  <= (idx_s == 6'd55);
                    r1_r        <= r1_s;
                    go_rd_r     <= go_rd_s;
                    go_wr_r     <= go_wr_s;
                    blk_r       <= blk_next_s;
                    aux_cnt_r   <= 8'd0;
                    data_cnt_r  <= 9'd0;
                end
            end
        end
    end

    // Data RAM: SPI write, SPI read prefetch and back-door read (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[byte_addr_s] <= rx_byte_s;
        end
        rd_data_r <= mem[byte_addr_s];
        bd_dout_r <= mem[bd_addr];
    end
endmodule

// File: tb/tb_sd_spi_card_model.sv
// Self-checking bench for sd_spi_card_model: command table, block write/read, abort with reset.
module tb_sd_spi_card_model;
    localparam int PH = 4;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [7:0]  r1;
        logic        idle;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bd_addr = 12'd0;
    logic [7:0]  bd_dout;
    logic        cmd_strobe;
    logic [5:0]  cmd_index;
    logic        in_idle;
    logic        wr_done;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int wr_cnt = 0;
    int exp_strobes = 0;
    logic [7:0] exp_q [$];
    vec_t vecs [18];

    sd_spi_card_model_if spi();

    sd_spi_card_model dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi.slave),
        .bd_addr    (bd_addr),
        .bd_dout    (bd_dout),
        .cmd_strobe (cmd_strobe),
        .cmd_index  (cmd_index),
        .in_idle    (in_idle),
        .wr_done    (wr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_strobe) strobe_cnt <= strobe_cnt + 1;
        if (wr_done) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi.sd_mosi = tx[i];
            repeat (PH) @(negedge clk);
            rx[i] = spi.sd_miso;
            spi.sd_sclk = 1'b1;
            repeat (PH) @(negedge clk);
            spi.sd_sclk = 1'b0;
        end
        spi.sd_mosi = 1'b1;
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] r1);
        logic [47:0] c;
        logic [7:0]  rx;
        c = {2'b01, idx, arg, 8'h95};
        exp_q.push_back(8'hFF);
        exp_q.push_back(r1);
        exp_strobes++;
        for (int b = 5; b >= 0; b--) xfer(c[b*8 +: 8], rx);
    endtask

    task automatic drain(input string name);
        logic [7:0] rx;
        while (exp_q.size() > 0) begin
            xfer(8'hFF, rx);
            check(name, {24'd0, rx}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic bd_check(input string name, input logic [11:0] a, input logic [7:0] exp);
        @(negedge clk);
        bd_addr = a;
        @(negedge clk);
        check(name, {24'd0, bd_dout}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] rx;
        vecs[0]  = '{6'd0,  32'h0000_0000, 8'h01, 1'b1};
        vecs[1]  = '{6'd17, 32'h0000_0400, 8'h05, 1'b1};
        vecs[2]  = '{6'd24, 32'h0000_0203, 8'h25, 1'b1};
        vecs[3]  = '{6'd8,  32'h0000_01AA, 8'h05, 1'b1};
        vecs[4]  = '{6'd41, 32'h4000_0000, 8'h05, 1'b1};
        vecs[5]  = '{6'd55, 32'h0000_0000, 8'h01, 1'b1};
        vecs[6]  = '{6'd41, 32'h4000_0000, 8'h01, 1'b1};
        vecs[7]  = '{6'd55, 32'h0000_0000, 8'h01, 1'b1};
        vecs[8]  = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};
        vecs[9]  = '{6'd17, 32'h0000_0401, 8'h20, 1'b0};
        vecs[10] = '{6'd24, 32'h0000_0203, 8'h20, 1'b0};
        vecs[11] = '{6'd55, 32'h0000_0000, 8'h00, 1'b0};
        vecs[12] = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};
        vecs[13] = '{6'd0,  32'h0000_0000, 8'h01, 1'b1};
        vecs[14] = '{6'd55, 32'h0000_0000, 8'h01, 1'b1};
        vecs[15] = '{6'd41, 32'h4000_0000, 8'h01, 1'b1};
        vecs[16] = '{6'd55, 32'h0000_0000, 8'h01, 1'b1};
        vecs[17] = '{6'd41, 32'h4000_0000, 8'h00, 1'b0};

        spi.sd_sclk = 1'b0;
        spi.sd_cs_n = 1'b1;
        spi.sd_mosi = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", {31'd0, spi.sd_miso}, 32'd1);
        check("reset_strobe", {31'd0, cmd_strobe}, 32'd0);
        check("reset_index", {26'd0, cmd_index}, 32'd0);
        check("reset_idle", {31'd0, in_idle}, 32'd1);
        check("reset_wr_done", {31'd0, wr_done}, 32'd0);
        spi.sd_cs_n = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 18; v++) begin
            send_cmd(vecs[v].idx, vecs[v].arg, vecs[v].r1);
            drain($sformatf("vec%0d_r1", v));
            check($sformatf("vec%0d_index", v), {26'd0, cmd_index}, {26'd0, vecs[v].idx});
            check($sformatf("vec%0d_idle", v), {31'd0, in_idle}, {31'd0, vecs[v].idle});
            check($sformatf("vec%0d_strobes", v), strobe_cnt, exp_strobes);
        end

        // Full block write to block 2 with data i & 0xFF
        send_cmd(6'd24, 32'h0000_0400, 8'h00);
        drain("wr_r1");
        xfer(8'hFF, rx);
        xfer(8'hFE, rx);
        for (int i = 0; i < 511; i++) xfer(8'(i), rx);
        check("wr_done_early", wr_cnt, 0);
        xfer(8'hFF, rx);
        check("wr_done_pulse", wr_cnt, 1);
        xfer(8'hAB, rx);
        xfer(8'hCD, rx);
        exp_q.push_back(8'h05);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        drain("wr_resp_busy");
        bd_check("bd_401", 12'h401, 8'h01);
        bd_check("bd_400", 12'h400, 8'h00);
        bd_check("bd_5ff", 12'h5FF, 8'hFF);

        // Block read back: gap, token, data, CRC, then idle line
        send_cmd(6'd17, 32'h0000_0400, 8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        drain("rd_stream");

        // Write aborted by cs_n after 100 bytes, then reset
        send_cmd(6'd24, 32'h0000_0400, 8'h00);
        drain("abort_r1");
        xfer(8'hFE, rx);
        for (int i = 0; i < 100; i++) xfer(~8'(i), rx);
        spi.sd_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_miso", {31'd0, spi.sd_miso}, 32'd1);
        check("abort_no_wr_done", wr_cnt, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_miso", {31'd0, spi.sd_miso}, 32'd1);
        check("rst2_idle", {31'd0, in_idle}, 32'd1);
        check("rst2_index", {26'd0, cmd_index}, 32'd0);
        for (int i = 0; i < 512; i++) begin
            bd_check($sformatf("abort_bd_%0d", i), 12'h400 + 12'(i), (i < 100) ? ~8'(i) : 8'(i));
        end
        spi.sd_cs_n = 1'b0;
        repeat (5) @(negedge clk);
        send_cmd(6'd0, 32'h0000_0000, 8'h01);
        drain("post_rst_cmd0");
        check("post_rst_strobes", strobe_cnt, exp_strobes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
